lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised pseudo-random generator and successor to the fixed 10-bit XNOR LFSR used by the tug-of-war computer player.
- Generalised in four ways:
  - any width from 3 to 32 bits, using maximal-length taps;
  - XNOR or XOR feedback;
  - multiple shift steps per enabled cycle;
  - run-time seed load, with lock-up state protection.
- Feeds comparators and game logic that need a random word or bit on each enabled cycle.

Parameters:
- WIDTH, 10, register width; legal range 3..32; taps come from the package table.
- XNOR_FB, 1, 1 = XNOR feedback (lock-up state is all-ones); 0 = XOR feedback (lock-up state is all-zeros).
- STEPS, 1, number of single-bit shifts applied per enabled cycle; legal range 1..WIDTH.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance the register by STEPS shifts this cycle.
- load  input  1  load seed this cycle.
- seed  input  WIDTH  load value.
- lfsr  output  WIDTH  current register state.
- rnd_bit  output  1  equals lfsr[0], the newest shifted-in bit.
- lockup_fix  output  1  one-cycle pulse when a lock-up seed was substituted.

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock is clk.
  - On reset, lfsr <= RST_VAL: all-zeros when XNOR_FB=1, 1 when XNOR_FB=0.
  - lockup_fix <= 0.
  - Reset overrides load and en.
- Single step, where t1 and t2 are the tap bit indices from the package table:
  - fb = lfsr[t1] ^ lfsr[t2], inverted when XNOR_FB=1.
  - next = {lfsr[WIDTH-2:0], fb}.
- Priority order is reset > load > en > hold.
- load=1:
  - lfsr <= seed on the next edge, with no shift that cycle even if en=1.
  - If seed equals the lock-up state, lfsr <= RST_VAL instead and lockup_fix pulses high for exactly the following cycle.
- en=1, load=0:
  - lfsr <= STEPS single steps applied to the current state, unrolled combinationally.
  - Latency is 1 cycle.
- en=0, load=0: lfsr holds its value.
- lockup_fix is registered. It is 0 in every cycle that does not immediately follow a substituted load.
- The lock-up state cannot be reached by stepping; only seed substitution guards it.
- Period: with STEPS=1 the sequence repeats every 2^WIDTH-1 enabled cycles.
- Outputs come directly from flops; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: LFSR_PERIOD_CHECK_EN.
- When defined, the block adds:
  - output period_cnt[WIDTH:0];
  - output period_done (1 bit).
- period_cnt behaviour:
  - Counts enabled steps since the last reset or load.
  - Cleared to 0 on reset or load.
  - Saturates at all-ones.
- period_done behaviour:
  - Pulses for one cycle when an enabled step returns lfsr to the start state, i.e. the value present right after reset or load.
  - On that same step, period_cnt is recaptured as the cycle length and then restarts counting from 0.
- When undefined, these ports and their logic do not exist.

Decomposition:
- Package lfsr_pkg holds:
  - function lfsr_taps(width), returning the two maximal-length tap indices for 3..32 (e.g. 10 -> 9,6; 4 -> 3,2);
  - function lfsr_lockup(width, xnor_fb);
  - function lfsr_rst_val(width, xnor_fb).
- Sub-module lfsr_step: a combinational single-step next-state function, instantiated STEPS times in a generate chain.

Test Plan:
- WIDTH=10, XNOR: reset, then en=1 for 3 cycles -> lfsr = 0x000, 0x001, 0x003, 0x007.
- WIDTH=10, XNOR: load seed 0x3FF -> lfsr = 0x000 and lockup_fix=1 for one cycle. Then load 0x155 -> lfsr = 0x155, lockup_fix=0.
- WIDTH=4, XOR: reset -> 0x1, then en steps -> 0x2, 0x4, 0x9. After 15 steps the register is back at 0x1, with all 15 nonzero values visited once.
- WIDTH=10, STEPS=2: reset, then one en cycle -> 0x003. Holding en=0 for 5 cycles keeps 0x003. load=1 together with en=1 and seed 0x0AA -> 0x0AA, unshifted.
- Assert reset after 50 steps, together with load=1 and en=1 -> lfsr = 0x000 next cycle and lockup_fix=0.
- With LFSR_PERIOD_CHECK_EN defined, WIDTH=10: reset, then 1023 en cycles -> period_done pulses on step 1023, lfsr = 0x000, and period_cnt reads 1023 that cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Tap table and reset/lock-up helpers shared by the LFSR generator.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

   // Feedback tap set. Bit indices are zero-based positions in the register.
   // Widths with a maximal-length trinomial use t1/t2 only. For widths where no
   // two-tap maximal sequence exists, four taps are needed to keep the period
   // at 2^WIDTH-1, and 'four' selects the extra pair t3/t4.
   typedef struct packed {
      logic [4:0] t1;
      logic [4:0] t2;
      logic [4:0] t3;
      logic [4:0] t4;
      logic       four;
   } taps_t;

   localparam int MIN_WIDTH = 3;
   localparam int MAX_WIDTH = 32;

   function automatic taps_t mk2(input int a, input int b);
      taps_t t;
      t.t1   = 5'(a);
      t.t2   = 5'(b);
      t.t3   = 5'd0;
      t.t4   = 5'd0;
      t.four = 1'b0;
      return t;
   endfunction

   function automatic taps_t mk4(input int a, input int b, input int c, input int d);
      taps_t t;
      t.t1   = 5'(a);
      t.t2   = 5'(b);
      t.t3   = 5'(c);
      t.t4   = 5'(d);
      t.four = 1'b1;
      return t;
   endfunction

   // Maximal-length taps for 3..32 bits (e.g. 10 -> 9,6; 4 -> 3,2).
   function automatic taps_t lfsr_taps(input int width);
      case (width)
         3:       return mk2( 2,  1);
         4:       return mk2( 3,  2);
         5:       return mk2( 4,  2);
         6:       return mk2( 5,  4);
         7:       return mk2( 6,  5);
         8:       return mk4( 7,  5,  4,  3);
         9:       return mk2( 8,  4);
         10:      return mk2( 9,  6);
         11:      return mk2(10,  8);
         12:      return mk4(11,  5,  3,  0);
         13:      return mk4(12,  3,  2,  0);
         14:      return mk4(13,  4,  2,  0);
         15:      return mk2(14, 13);
         16:      return mk4(15, 14, 12,  3);
         17:      return mk2(16, 13);
         18:      return mk2(17, 10);
         19:      return mk4(18,  5,  1,  0);
         20:      return mk2(19, 16);
         21:      return mk2(20, 18);
         22:      return mk2(21, 20);
         23:      return mk2(22, 17);
         24:      return mk4(23, 22, 21, 16);
         25:      return mk2(24, 21);
         26:      return mk4(25,  5,  1,  0);
         27:      return mk4(26,  4,  1,  0);
         28:      return mk2(27, 24);
         29:      return mk2(28, 26);
         30:      return mk4(29,  5,  3,  0);
         31:      return mk2(30, 27);
         32:      return mk4(31, 21,  1,  0);
         default: return mk2( 2,  1);
      endcase
   endfunction

   // The one state the feedback maps onto itself: all-ones for XNOR, zero for XOR.
   function automatic logic [31:0] lfsr_lockup(input int width, input int xnor_fb);
      logic [31:0] v;
      v = 32'd0;
      if (xnor_fb != 0) begin
         for (int i = 0; i < 32; i++) begin
            if (i < width) v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   // Start state: all-zeros for XNOR, one for XOR (never the lock-up state).
   function automatic logic [31:0] lfsr_rst_val(input int width, input int xnor_fb);
      if (width < MIN_WIDTH) return 32'd1;
      return (xnor_fb != 0) ? 32'd0 : 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_gen_step.sv
// ---------------------------------------------------------------------------
// lfsr_step
// Combinational single-shift next-state function of the LFSR.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int WIDTH   = 10,
   parameter int XNOR_FB = 1
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   localparam taps_t TAPS = lfsr_taps(WIDTH);
   localparam int    T1   = int'(TAPS.t1);
   localparam int    T2   = int'(TAPS.t2);
   localparam int    T3   = int'(TAPS.t3);
   localparam int    T4   = int'(TAPS.t4);

   logic raw;
   logic fb;

   generate
      if (TAPS.four) begin : g_four_tap
         assign raw = cur[T1] ^ cur[T2] ^ cur[T3] ^ cur[T4];
      end else begin : g_two_tap
         assign raw = cur[T1] ^ cur[T2];
      end
   endgenerate

   // XNOR feedback keeps all-zeros as a legal state and makes all-ones the trap.
   assign fb  = (XNOR_FB != 0) ? ~raw : raw;
   assign nxt = {cur[WIDTH-2:0], fb};

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
// Parametrised XNOR/XOR LFSR with multi-step advance, seed load and
// lock-up seed substitution.
// Optional macro LFSR_PERIOD_CHECK_EN adds period_cnt / period_done.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int WIDTH   = 10,
   parameter int XNOR_FB = 1,
   parameter int STEPS   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] lfsr,
   output logic             rnd_bit,
   output logic             lockup_fix
`ifdef LFSR_PERIOD_CHECK_EN
   ,
   output logic [WIDTH:0]   period_cnt,
   output logic             period_done
`endif
);

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(lfsr_rst_val(WIDTH, XNOR_FB));
   localparam logic [WIDTH-1:0] LOCKUP  = WIDTH'(lfsr_lockup(WIDTH, XNOR_FB));

   // chain[0] is the current state, chain[STEPS] the state after STEPS shifts.
   logic [WIDTH-1:0] chain [0:STEPS];
   logic             seed_is_lockup;

   assign chain[0]       = lfsr;
   assign seed_is_lockup = (seed == LOCKUP);

   generate
      for (genvar g = 0; g < STEPS; g++) begin : g_step
         lfsr_step #(
            .WIDTH   (WIDTH),
            .XNOR_FB (XNOR_FB)
         ) u_step (
            .cur (chain[g]),
            .nxt (chain[g+1])
         );
      end
   endgenerate

   // State register: reset > load (with lock-up substitution) > en > hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr       <= RST_VAL;
         lockup_fix <= 1'b0;
      end else if (load) begin
         lfsr       <= seed_is_lockup ? RST_VAL : seed;
         lockup_fix <= seed_is_lockup;
      end else begin
         lockup_fix <= 1'b0;
         if (en) lfsr <= chain[STEPS];
      end
   end

   assign rnd_bit = lfsr[0];

`ifdef LFSR_PERIOD_CHECK_EN
   logic [WIDTH-1:0] start_val;
   logic             wrap_pending;
   logic [WIDTH:0]   cnt_base;
   logic [WIDTH:0]   cnt_inc;

   // After a completed period the next enabled step counts from zero again.
   always_comb begin
      cnt_base = wrap_pending ? '0 : period_cnt;
      cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + (WIDTH+1)'(1);
   end

   // Step counter and period-complete detector against the start state.
   always_ff @(posedge clk) begin
      if (reset || load) begin
         period_cnt   <= '0;
         period_done  <= 1'b0;
         wrap_pending <= 1'b0;
         start_val    <= (reset || seed_is_lockup) ? RST_VAL : seed;
      end else if (en) begin
         period_cnt   <= cnt_inc;
         period_done  <= (chain[STEPS] == start_val);
         wrap_pending <= (chain[STEPS] == start_val);
      end else begin
         period_done  <= 1'b0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_gen
// Directed, table-driven bench for lfsr_gen in three configurations:
//   a: WIDTH=10 XNOR STEPS=1, b: WIDTH=4 XOR STEPS=1, c: WIDTH=10 XNOR STEPS=2.
// Honours LFSR_PERIOD_CHECK_EN when defined.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Configuration a
   logic       a_reset = 1'b0, a_load = 1'b0, a_en = 1'b0;
   logic [9:0] a_seed = '0, a_lfsr;
   logic       a_bit, a_fix;
   // Configuration b
   logic       b_reset = 1'b0, b_load = 1'b0, b_en = 1'b0;
   logic [3:0] b_seed = '0, b_lfsr;
   logic       b_bit, b_fix;
   // Configuration c
   logic       c_reset = 1'b0, c_load = 1'b0, c_en = 1'b0;
   logic [9:0] c_seed = '0, c_lfsr;
   logic       c_bit, c_fix;

`ifdef LFSR_PERIOD_CHECK_EN
   logic [10:0] a_pcnt, c_pcnt;
   logic [4:0]  b_pcnt;
   logic        a_pdone, b_pdone, c_pdone;
`endif

   lfsr_gen #(.WIDTH(10), .XNOR_FB(1), .STEPS(1)) u_a (
      .clk(clk), .reset(a_reset), .en(a_en), .load(a_load), .seed(a_seed),
      .lfsr(a_lfsr), .rnd_bit(a_bit), .lockup_fix(a_fix)
`ifdef LFSR_PERIOD_CHECK_EN
      , .period_cnt(a_pcnt), .period_done(a_pdone)
`endif
   );

   lfsr_gen #(.WIDTH(4), .XNOR_FB(0), .STEPS(1)) u_b (
      .clk(clk), .reset(b_reset), .en(b_en), .load(b_load), .seed(b_seed),
      .lfsr(b_lfsr), .rnd_bit(b_bit), .lockup_fix(b_fix)
`ifdef LFSR_PERIOD_CHECK_EN
      , .period_cnt(b_pcnt), .period_done(b_pdone)
`endif
   );

   lfsr_gen #(.WIDTH(10), .XNOR_FB(1), .STEPS(2)) u_c (
      .clk(clk), .reset(c_reset), .en(c_en), .load(c_load), .seed(c_seed),
      .lfsr(c_lfsr), .rnd_bit(c_bit), .lockup_fix(c_fix)
`ifdef LFSR_PERIOD_CHECK_EN
      , .period_cnt(c_pcnt), .period_done(c_pdone)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference for the 4-bit XOR register (x^4+x^3+1 taps).
   function automatic logic [3:0] ref_step4(input logic [3:0] x);
      return {x[2:0], x[3] ^ x[2]};
   endfunction

   typedef struct {
      logic       rst;
      logic       ld;
      logic       en;
      logic [9:0] seed;
      logic [9:0] exp_lfsr;
      logic       exp_fix;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [3:0]  b_exp;
      logic [15:0] visited;
      logic [3:0]  first3 [3];
      int          early_done;

      // {reset, load, en, seed, expected lfsr, expected lockup_fix}
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h001, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h003, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h007, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h007, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 10'h3FF, 10'h000, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'h155, 10'h155, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h2AA, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 10'h000, 10'h154, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 10'h3FF, 10'h000, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 10'h3FF, 10'h000, 1'b0};

      first3[0] = 4'h2;
      first3[1] = 4'h4;
      first3[2] = 4'h9;

      tick();

      // Table for configuration a
      for (int i = 0; i < 12; i++) begin
         a_reset = tbl[i].rst;
         a_load  = tbl[i].ld;
         a_en    = tbl[i].en;
         a_seed  = tbl[i].seed;
         tick();
         chk($sformatf("a_lfsr[%0d]", i), 32'(a_lfsr), 32'(tbl[i].exp_lfsr));
         chk($sformatf("a_fix[%0d]", i), 32'(a_fix), 32'(tbl[i].exp_fix));
         chk($sformatf("a_bit[%0d]", i), 32'(a_bit), 32'(tbl[i].exp_lfsr[0]));
      end
      a_reset = 1'b0; a_load = 1'b0; a_en = 1'b0;

      // Reset after 50 steps, with load and en also high
      a_reset = 1'b1; tick(); a_reset = 1'b0;
      a_en = 1'b1;
      for (int i = 0; i < 50; i++) tick();
      chk("a_moved_after_50", 32'(a_lfsr != 10'h000), 32'd1);
      a_reset = 1'b1; a_load = 1'b1; a_seed = 10'h0AA;
      tick();
      chk("a_reset_prio_lfsr", 32'(a_lfsr), 32'h000);
      chk("a_reset_prio_fix", 32'(a_fix), 32'd0);
      a_reset = 1'b0; a_load = 1'b0; a_en = 1'b0;

      // Configuration b: full period of the 4-bit XOR register
      b_reset = 1'b1; tick(); b_reset = 1'b0;
      chk("b_reset", 32'(b_lfsr), 32'h1);
      b_exp   = 4'h1;
      visited = 16'h0002;
      b_en    = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         b_exp = ref_step4(b_exp);
         if (i <= 3) chk($sformatf("b_first_step%0d", i), 32'(b_lfsr), 32'(first3[i-1]));
         else        chk($sformatf("b_step%0d", i), 32'(b_lfsr), 32'(b_exp));
         if (i < 15) visited[b_lfsr] = 1'b1;
      end
      b_en = 1'b0;
      chk("b_period_back_to_1", 32'(b_lfsr), 32'h1);
      chk("b_all_nonzero_visited", 32'(visited), 32'hFFFE);
      b_load = 1'b1; b_seed = 4'h0; tick(); b_load = 1'b0;
      chk("b_lockup_sub_lfsr", 32'(b_lfsr), 32'h1);
      chk("b_lockup_sub_fix", 32'(b_fix), 32'd1);
      tick();
      chk("b_fix_one_cycle", 32'(b_fix), 32'd0);

      // Configuration c: two shifts per enabled cycle
      c_reset = 1'b1; tick(); c_reset = 1'b0;
      chk("c_reset", 32'(c_lfsr), 32'h000);
      c_en = 1'b1; tick(); c_en = 1'b0;
      chk("c_two_steps", 32'(c_lfsr), 32'h003);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("c_hold%0d", i), 32'(c_lfsr), 32'h003);
      end
      c_load = 1'b1; c_en = 1'b1; c_seed = 10'h0AA; tick();
      c_load = 1'b0; c_en = 1'b0;
      chk("c_load_no_shift", 32'(c_lfsr), 32'h0AA);
      chk("c_load_fix", 32'(c_fix), 32'd0);
      c_en = 1'b1; tick(); c_en = 1'b0;
      // 0x0AA -> 0x155 (fb=1) -> 0x2AA (fb=0)
      chk("c_two_steps_from_seed", 32'(c_lfsr), 32'h2AA);

`ifdef LFSR_PERIOD_CHECK_EN
      a_reset = 1'b1; tick(); a_reset = 1'b0;
      chk("a_pcnt_reset", 32'(a_pcnt), 32'd0);
      early_done = 0;
      a_en = 1'b1;
      for (int i = 1; i < 1023; i++) begin
         tick();
         if (a_pdone !== 1'b0) early_done++;
      end
      chk("a_pdone_early", 32'(early_done), 32'd0);
      tick();
      chk("a_pdone_1023", 32'(a_pdone), 32'd1);
      chk("a_pcnt_1023", 32'(a_pcnt), 32'd1023);
      chk("a_period_lfsr", 32'(a_lfsr), 32'h000);
      tick();
      a_en = 1'b0;
      chk("a_pdone_pulse", 32'(a_pdone), 32'd0);
      chk("a_pcnt_restart", 32'(a_pcnt), 32'd1);
`else
      early_done = 0;
      if (early_done != 0) $display("unused");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
